// File: rtl/posit_decode_pipe_if.sv
// Handshake bundle for the posit decoder: an encoded-posit input channel and a
// decoded-field output channel, each with its own valid/ready pair.
interface posit_decode_pipe_if #(
    parameter int N  = 8,
    parameter int ES = 1
);
    localparam int RS = $clog2(N);
    localparam int SW = RS + ES + 2;
    localparam int MW = N - ES - 2;

    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [N-1:0]         in_posit_i;

    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 out_sign_o;
    logic signed [SW-1:0] out_scale_o;
    logic [MW-1:0]        out_mant_o;
    logic                 out_zero_o;
    logic                 out_nar_o;

    modport master (
        output in_valid_i, in_posit_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_sign_o, out_scale_o,
               out_mant_o, out_zero_o, out_nar_o
    );

    modport slave (
        input  in_valid_i, in_posit_i, out_ready_i,
        output in_ready_o, out_valid_o, out_sign_o, out_scale_o,
               out_mant_o, out_zero_o, out_nar_o
    );
endinterface

// File: rtl/posit_decode_pipe.sv
// Two-stage posit decoder: stage 1 takes the magnitude, stage 2 splits the
// regime/exponent/fraction fields into a signed scale and a normalised mantissa.
package posit_pkg;
    typedef enum logic [1:0] {
        POSIT8_ES1  = 2'd0,
        POSIT16_ES1 = 2'd1,
        POSIT16_ES2 = 2'd2,
        POSIT32_ES2 = 2'd3
    } posit_format_e;

    function automatic int posit_width(posit_format_e f);
        case (f)
            POSIT8_ES1:               return 8;
            POSIT16_ES1, POSIT16_ES2: return 16;
            default:                  return 32;
        endcase
    endfunction

    function automatic int exp_bits(posit_format_e f);
        case (f)
            POSIT8_ES1, POSIT16_ES1: return 1;
            default:                 return 2;
        endcase
    endfunction
endpackage

module posit_decode_pipe
    import posit_pkg::*;
#(
    parameter posit_format_e pFormat = posit_format_e'(0)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    posit_decode_pipe_if.slave io
);
    localparam int N  = posit_width(pFormat);
    localparam int ES = exp_bits(pFormat);
    localparam int RS = $clog2(N);
    localparam int MW = N - ES - 2;
    localparam int SW = RS + ES + 2;

    logic          s1_valid;
    logic          s2_valid;
    logic          s1_sign;
    logic [N-2:0]  s1_body;
    logic          s1_zero;
    logic          s1_nar;

    logic          s2_ready;
    logic          s1_advance;
    logic          load_s1;
    logic [N-2:0]  in_body;

    logic          run_bit;
    logic [RS-1:0] run_len;
    logic          run_open;
    logic [RS:0]   sh_amt;
    logic [N-2:0]  shifted;
    logic [N-4:0]  ef_bits;
    logic [RS:0]   k_bits;
    logic [SW-1:0] scale_comb;

    assign s2_ready      = !s2_valid || io.out_ready_i;
    assign s1_advance    = s1_valid && s2_ready;
    assign io.in_ready_o = (!s1_valid || s1_advance) && !flush_i;
    assign io.out_valid_o = s2_valid;
    assign load_s1       = io.in_valid_i && io.in_ready_o;

    // Low bits of a two's-complement negation depend only on the low bits.
    assign in_body = io.in_posit_i[N-1] ? (-io.in_posit_i[N-2:0]) : io.in_posit_i[N-2:0];

    always_comb begin
        run_bit  = s1_body[N-2];
        run_len  = '0;
        run_open = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (run_open && (s1_body[i] == run_bit)) begin
                run_len = run_len + RS'(1);
            end else begin
                run_open = 1'b0;
            end
        end
    end

    // Shifting out the run plus its terminator leaves exponent then fraction at the top;
    // a shift of N (no terminator) clears everything, giving the implicit zero bits.
    assign sh_amt     = {1'b0, run_len} + (RS+1)'(1);
    assign shifted    = s1_body << sh_amt;
    assign ef_bits    = (N-3)'(shifted >> 2);
    assign k_bits     = run_bit ? ({1'b0, run_len} - (RS+1)'(1)) : (-{1'b0, run_len});
    assign scale_comb = ({{(ES+1){k_bits[RS]}}, k_bits} << ES) | SW'(ef_bits[N-4 -: ES]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_ready) begin
                s2_valid <= s1_valid;
            end
            if (!s1_valid || s1_advance) begin
                s1_valid <= io.in_valid_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_s1) begin
            s1_sign <= io.in_posit_i[N-1];
            s1_body <= in_body;
            s1_zero <= (io.in_posit_i == '0);
            s1_nar  <= io.in_posit_i[N-1] && (io.in_posit_i[N-2:0] == '0);
        end
        if (s1_advance) begin
            io.out_sign_o <= s1_sign;
            io.out_zero_o <= s1_zero;
            io.out_nar_o  <= s1_nar;
            if (s1_zero || s1_nar) begin
                io.out_scale_o <= '0;
                io.out_mant_o  <= '0;
            end else begin
                io.out_scale_o <= scale_comb;
                io.out_mant_o  <= {1'b1, ef_bits[MW-2:0]};
            end
        end
    end
endmodule

// File: doc/posit_decode_pipe.md
POSIT_DECODE_PIPE -- requirements
Module: posit_decode_pipe

Interface
REQ-001 SHALL have parameter pFormat, type posit_pkg::posit_format_e, default posit_pkg::posit_format_e'(0), selecting the posit format.
REQ-002 SHALL derive localparams N = posit_pkg::posit_width(pFormat), ES = posit_pkg::exp_bits(pFormat) and RS = $clog2(N); MW = N-ES-2 is the mantissa width.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 flush_i  input  1  synchronous pipeline clear.
REQ-006 in_valid_i  input  1  an encoded posit is presented.
REQ-007 in_ready_o  output  1  block accepts the posit this cycle.
REQ-008 in_posit_i  input  N  raw posit word.
REQ-009 out_valid_o  output  1  decoded result available.
REQ-010 out_ready_i  input  1  consumer takes the result this cycle.
REQ-011 out_sign_o  output  1  posit sign bit.
REQ-012 out_scale_o  output  RS+ES+2 signed  scale = k*2^ES + e.
REQ-013 out_mant_o  output  MW  hidden bit at MSB, fraction left-aligned, zero-padded.
REQ-014 out_zero_o / out_nar_o  output  1 each  input was zero / NaR.

Function
REQ-015 Stage 1 SHALL register sign = in_posit_i[N-1] and body = the two's-complement magnitude's low N-1 bits; it SHALL also register zero/NaR flags (zero: word all 0; NaR: MSB 1, rest 0).
REQ-016 Stage 2 SHALL find the run length R of identical bits starting at body[N-2], where R is the count of equal leading bits, from 1 to N-1.
REQ-017 Stage 2 SHALL compute k = R-1 when body[N-2]=1 and k = -R when body[N-2]=0.
REQ-018 After the run, stage 2 SHALL skip one terminator bit, if present.
REQ-019 Stage 2 SHALL then take the next ES bits as e, with missing bits read as 0.
REQ-020 The remaining bits SHALL form the fraction, with missing bits read as 0.
REQ-021 Scale SHALL be sign-extended exactly; no saturation is needed because the range fits RS+ES+2 bits.
REQ-022 For zero or NaR inputs, scale and mant SHALL be 0 and the respective flag set; the sign output SHALL be the registered sign.
REQ-023 Handshake: a transfer occurs when valid and ready are both high. out_valid_o SHALL NOT depend combinationally on out_ready_i. Payload SHALL be held stable while out_valid_o=1 and out_ready_i=0.
REQ-024 Latency SHALL be 2 cycles from input transfer to out_valid_o with no stall; throughput SHALL be 1 per cycle.
REQ-025 Backpressure: each stage SHALL advance only if its downstream is empty or draining.
REQ-026 in_ready_o = !s1_valid || s1_advance, and SHALL be forced low while flush_i=1.
REQ-027 flush_i SHALL clear both stage valids on the next edge and SHALL win over a simultaneous input transfer; that input SHALL be dropped.
REQ-028 No bubble SHALL be inserted when both stages are full and out_ready_i=1; the pipeline SHALL shift fully.
REQ-029 Data registers MAY be non-reset; valid registers SHALL be reset.

Reset
REQ-030 On rst_ni=0, asynchronously: s1_valid=0, s2_valid=0, out_valid_o=0, in_ready_o=1 (combinational, after reset).
REQ-031 A reset mid-stall SHALL discard all in-flight results; the first valid after release SHALL correspond to a post-reset input.

Verification (N=8, ES=1, MW=5)
REQ-032 Input 0x40 -> two cycles later: sign 0, scale 0, mant 0x10, flags 0.
REQ-033 Inputs 0x60, 0x50, 0x48 back-to-back with out_ready_i=1 -> consecutive cycles give (scale 2, mant 0x10), (1, 0x10), (0, 0x18).
REQ-034 Input 0xC0 -> sign 1, scale 0, mant 0x10.
REQ-035 Input 0x7F -> scale 12, mant 0x10.
REQ-036 Input 0x01 -> scale -12, mant 0x10.
REQ-037 Input 0x00 -> zero=1; input 0x80 -> nar=1; scale=0 and mant=0 in both cases.
REQ-038 Hold out_ready_i=0 for 5 cycles with 3 inputs offered -> exactly 2 accepted, outputs stable, then in order with no loss or duplicates on release.
REQ-039 Flush asserted with in_valid_i=1 and both stages full -> next cycle out_valid_o=0, offered input not accepted.
REQ-040 rst_ni pulsed low mid-stall -> out_valid_o drops immediately.
